// File: rtl/ram_sweep_pkg.sv
// ram_sweep_pkg
// Shared definitions for the RAM read-out sequencer:
//   sweep_state_t  - sequencer FSM states
//   SWEEP_ADDR_W   - default RAM address width
//   SWEEP_DATA_W   - default RAM word width
//   dwell_w()      - width of the dwell down-counter for a given DWELL
package ram_sweep_pkg;

    localparam int SWEEP_ADDR_W = 4;
    localparam int SWEEP_DATA_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_DWELL   = 3'd3,
        ST_COPY_RD = 3'd4,
        ST_COPY_WR = 3'd5
    } sweep_state_t;

    // The counter holds DWELL-1 down to 0, so $clog2(DWELL) bits suffice
    // (DWELL is at least 2).
    function automatic int dwell_w(input int dwell);
        return $clog2(dwell);
    endfunction

endpackage

// File: rtl/ram_sweep_ctrl_timer.sv
// sweep_dwell_timer
// Loadable down-counter that times how long each address is held during
// auto-sweep. It stops at zero and reports that through done.
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset (count clears to 0)
//   load     in   load load_val this cycle (takes priority over en)
//   load_val in   CNT_W value to load
//   en       in   decrement while nonzero
//   done     out  count is zero
module sweep_dwell_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/ram_sweep_ctrl.sv
// ram_sweep_ctrl
// Read-out sequencer for the dual RAM pair feeding the display path. It drives
// the shared RAM address, captures both RAM words one cycle later and shows
// address, both words and a mismatch flag. Supports auto-sweep (run), manual
// stepping (step) and, when the RAM_SWEEP_COPY_EN macro is defined, a one-shot
// bulk copy of ram0 into ram1 (copy_req). Without the macro the copy states are
// not built, copy_req is ignored and ram1_wr / ram1_wdata / busy are tied to 0.
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   run, step, copy_req    auto-sweep level, step pulse, copy request pulse
//   ram0_rdata, ram1_rdata RAM read data (1-cycle latency after addr)
//   addr                   address to both RAMs
//   ram1_wr, ram1_wdata    ram1 write port (copy only)
//   disp_addr, disp0, disp1, mismatch  registered display values
//   busy                   copy in progress
module ram_sweep_ctrl
    import ram_sweep_pkg::*;
#(
    parameter int ADDR_W = SWEEP_ADDR_W,
    parameter int DATA_W = SWEEP_DATA_W,
    parameter int DWELL  = 50_000_000
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              run,
    input  logic              step,
    input  logic              copy_req,
    input  logic [DATA_W-1:0] ram0_rdata,
    input  logic [DATA_W-1:0] ram1_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              ram1_wr,
    output logic [DATA_W-1:0] ram1_wdata,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp0,
    output logic [DATA_W-1:0] disp1,
    output logic              mismatch,
    output logic              busy
);

    localparam int CNT_W = dwell_w(DWELL);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL - 1);

    sweep_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] disp_addr_reg;
    logic [DATA_W-1:0] disp0_reg, disp1_reg;
    logic              mismatch_reg;
    logic              latch_en;
    logic              dwell_load;
    logic              dwell_done;

    sweep_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .resetn   (resetn),
        .load     (dwell_load),
        .load_val (DWELL_LOAD),
        .en       (state_reg == ST_DWELL),
        .done     (dwell_done)
    );

`ifdef RAM_SWEEP_COPY_EN
    logic copy_go;
    assign copy_go = copy_req;
`else
    logic copy_go;
    logic unused_copy_req;
    assign copy_go         = 1'b0;
    assign unused_copy_req = copy_req;
`endif

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        latch_en   = 1'b0;
        dwell_load = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (copy_go) begin
                    addr_next  = '0;
                    state_next = ST_COPY_RD;
                end else if (step) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = ST_FETCH;
                end else if (run) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: state_next = ST_LATCH;
            ST_LATCH: begin
                latch_en = 1'b1;
                if (run) begin
                    dwell_load = 1'b1;
                    state_next = ST_DWELL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DWELL: begin
                // run is only sampled once the dwell has expired
                if (dwell_done) begin
                    addr_next  = addr_reg + 1'b1;
                    state_next = run ? ST_FETCH : ST_IDLE;
                end
            end
`ifdef RAM_SWEEP_COPY_EN
            ST_COPY_RD: state_next = ST_COPY_WR;
            ST_COPY_WR: begin
                // Increment wraps to 0 after the last word; then refresh display
                addr_next  = addr_reg + 1'b1;
                state_next = (addr_reg == '1) ? ST_FETCH : ST_COPY_RD;
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= ST_FETCH;
            addr_reg      <= '0;
            disp_addr_reg <= '0;
            disp0_reg     <= '0;
            disp1_reg     <= '0;
            mismatch_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            if (latch_en) begin
                disp_addr_reg <= addr_reg;
                disp0_reg     <= ram0_rdata;
                disp1_reg     <= ram1_rdata;
                mismatch_reg  <= (ram0_rdata != ram1_rdata);
            end
        end
    end

`ifdef RAM_SWEEP_COPY_EN
    logic ram1_wr_reg;
    logic busy_reg;

    // Registered decodes of the state being entered, so both match the state
    // exactly and clear asynchronously on reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ram1_wr_reg <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            ram1_wr_reg <= (state_next == ST_COPY_WR);
            busy_reg    <= (state_next == ST_COPY_RD) || (state_next == ST_COPY_WR);
        end
    end

    assign ram1_wr    = ram1_wr_reg;
    assign ram1_wdata = ram1_wr_reg ? ram0_rdata : '0;
    assign busy       = busy_reg;
`else
    assign ram1_wr    = 1'b0;
    assign ram1_wdata = '0;
    assign busy       = 1'b0;
`endif

    assign addr      = addr_reg;
    assign disp_addr = disp_addr_reg;
    assign disp0     = disp0_reg;
    assign disp1     = disp1_reg;
    assign mismatch  = mismatch_reg;

endmodule

// File: doc/ram_sweep_ctrl.md
# ram_sweep_ctrl

Read-out sequencer that sits downstream of the dual 16×4 RAM pair and replaces manual address selection for the display path. It drives the shared RAM address, captures both RAM outputs one cycle later, and presents address, ram0 word, ram1 word and a mismatch flag to the seven-segment decoders. It also supports manual stepping and a one-shot bulk copy of ram0 into ram1.

## Interface
- `ADDR_W`, 4: RAM address width; the sweep covers 2^ADDR_W words.
- `DATA_W`, 4: RAM word width.
- `DWELL`, 50_000_000: clock cycles each address is held during auto-sweep. Must be ≥2.
- `clk`  in  1  single system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; while high, auto-sweep advances one address every DWELL cycles.
- `step`  in  1  single-cycle pulse; advances one address when idle.
- `copy_req`  in  1  single-cycle pulse; starts the ram0→ram1 bulk copy when idle.
- `ram0_rdata`  in  DATA_W  ram0 output; valid one cycle after `addr` changes.
- `ram1_rdata`  in  DATA_W  ram1 output; same latency as ram0.
- `addr`  out  ADDR_W  address driven to both RAMs.
- `ram1_wr`  out  1  ram1 write enable; high only in COPY_WR.
- `ram1_wdata`  out  DATA_W  ram1 write data; equals `ram0_rdata` in COPY_WR, 0 otherwise.
- `disp_addr`  out  ADDR_W  registered address of the displayed words.
- `disp0`, `disp1`  out  DATA_W  registered ram0 and ram1 words.
- `mismatch`  out  1  registered flag; high when `disp0` ≠ `disp1`.
- `busy`  out  1  high in COPY_RD and COPY_WR.

## Operation
- **States:** IDLE, FETCH, LATCH, DWELL, COPY_RD, COPY_WR.
- **FETCH:** `addr` is stable. Always advances to LATCH on the next cycle.
- **LATCH:** captures `disp_addr`←`addr`, `disp0`←`ram0_rdata`, `disp1`←`ram1_rdata`, `mismatch`←(ram0_rdata≠ram1_rdata).
  - If `run` is high, the next state is DWELL; otherwise it is IDLE.
- **DWELL:** the counter loads DWELL−1 on entry and decrements each cycle. At 0:
  - `addr` increments, wrapping from 2^ADDR_W−1 to 0.
  - The next state is FETCH if `run` is high, else IDLE.
  - If `run` drops mid-dwell, the dwell finishes first.
- **IDLE priorities** (highest first):
  - `copy_req`: `addr`←0, go to COPY_RD.
  - `step`: `addr`←`addr`+1 with wrap, go to FETCH.
  - `run`: go to FETCH at the current `addr`.
- **Ignored inputs:** `step` and `copy_req` outside IDLE are dropped, not queued.
- **Copy sequence:**
  - COPY_RD: holds `addr` for one read cycle.
  - COPY_WR: asserts `ram1_wr`, with `ram1_wdata`=`ram0_rdata`.
  - After COPY_WR, if `addr` is the last word, `addr` wraps to 0 and the next state is FETCH to refresh the display. Otherwise `addr` increments and the next state is COPY_RD.
- **Reset values:** state=FETCH, `addr`=0, `disp_addr`=0, `disp0`=0, `disp1`=0, `mismatch`=0, `ram1_wr`=0, `busy`=0, dwell counter=0. Address 0 is therefore shown automatically after reset.
- **Reset mid-copy:** aborts the copy immediately. `ram1_wr` drops asynchronously. Words already written stay written.

## Timing
- Display latency: 2 cycles from entering FETCH to new `disp*` values (FETCH, then LATCH).
- Auto-sweep period: DWELL+2 cycles per address.
- Full copy: 2·2^ADDR_W cycles (32 at defaults), plus 2 cycles of display refresh.
- `ram1_wr` is high for exactly one cycle per word, with `addr` stable across both the read and write cycles.
- All outputs are registered except `ram1_wdata`, which is a combinational pass-through gated by the COPY_WR decode.

## Configuration
- **`RAM_SWEEP_COPY_EN` defined:** copy mode is built as described.
- **`RAM_SWEEP_COPY_EN` undefined:**
  - COPY_RD and COPY_WR are removed and `copy_req` is ignored.
  - `ram1_wr`, `ram1_wdata` and `busy` are tied to 0.
  - The port list is unchanged.

## Structure
- **Package `ram_sweep_pkg`:**
  - state enum `sweep_state_t`;
  - default constants `SWEEP_ADDR_W`=4 and `SWEEP_DATA_W`=4;
  - dwell counter width function `dwell_w(DWELL)` = $clog2(DWELL).
- **Sub-module `sweep_dwell_timer`:** loadable down-counter with a `done` output. Used by DWELL.
- FSM, address register and display registers live in the top module.

## Test plan
All scenarios use DWELL=4 and behavioural RAMs with 1-cycle read latency, preloaded with ram0[i]=i and ram1[i]=15−i.
- **Reset release:** `run`=0 → after 2 cycles `disp_addr`=0, `disp0`=0, `disp1`=15, `mismatch`=1, then IDLE.
- **Auto-sweep:** `run`=1 for 6·16 cycles → `disp_addr` walks 0..15..0 with a 6-cycle period; the wrap from 15 to 0 is checked.
- **Step:**
  - `step` pulse in IDLE at addr 7 → `disp_addr`=8, `disp0`=8, `disp1`=7.
  - `step` pulse during DWELL → no effect.
- **Copy:** `copy_req` → `busy` is high for 32 cycles, with 16 one-cycle `ram1_wr` pulses writing ram1[i]=i. Afterwards, a full sweep shows `mismatch`=0 at every address.
- **Simultaneous inputs:** `copy_req`, `step` and `run` all high in the same IDLE cycle → copy wins and `addr` starts at 0.
- **Reset mid-copy:** assert `resetn`=0 after 5 writes → `ram1_wr` drops immediately. ram1[0..4]=0..4, ram1[5..15] unchanged, outputs at reset values.
